// File: rtl/pipe_stage_skid_pkg.sv
// Shared state encoding and EX/MEM payload layout for the handshaked pipeline stage.
// The payload packer lets stage instances build their bubble value from named fields.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PSTG_EMPTY = 2'd0,
    PSTG_ONE   = 2'd1,
    PSTG_TWO   = 2'd2
  } pstg_state_e;

  localparam int EX_MEM_PAYLOAD_W = 157;

  // Field offsets, LSB first: funct3, opcode, csr_wdata, wdata, csr_wreg, wreg, csr_waddr, rd_addr
  localparam int EXM_FUNCT3_LSB    = 0;
  localparam int EXM_OPCODE_LSB    = 3;
  localparam int EXM_CSR_WDATA_LSB = 10;
  localparam int EXM_WDATA_LSB     = 74;
  localparam int EXM_CSR_WREG_LSB  = 138;
  localparam int EXM_WREG_LSB      = 139;
  localparam int EXM_CSR_WADDR_LSB = 140;
  localparam int EXM_RD_ADDR_LSB   = 152;

  function automatic logic [EX_MEM_PAYLOAD_W-1:0] exMemPack(
    input logic [4:0]  rdAddr,
    input logic [11:0] csrWaddr,
    input logic        wreg,
    input logic        csrWreg,
    input logic [63:0] wdata,
    input logic [63:0] csrWdata,
    input logic [6:0]  opcode,
    input logic [2:0]  funct3
  );
    return {rdAddr, csrWaddr, wreg, csrWreg, wdata, csrWdata, opcode, funct3};
  endfunction

  // addi x0, x0, 0 : writes x0, so it is architecturally a no-op
  localparam logic [EX_MEM_PAYLOAD_W-1:0] EX_MEM_BUBBLE =
    exMemPack(5'd0, 12'd0, 1'b1, 1'b0, 64'd0, 64'd0, 7'b0010011, 3'b000);

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One payload register with load enable; data is deliberately not reset since
// the stage's valid state alone decides whether the contents are meaningful.
module pipe_slot #(
  parameter int DATA_W = 157
) (
  input  logic              clk,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (i_load) r_data <= i_data;
  end

  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with optional 2-entry skid buffer, flush and a
// bubble payload presented whenever the stage holds nothing.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                 DATA_W     = EX_MEM_PAYLOAD_W,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}},
  parameter bit                 SKID_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  pstg_state_e       r_state;
  pstg_state_e       w_state_nxt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_load;
  logic              w_main_sel_skid;
  logic [DATA_W-1:0] w_main_d;
  logic [DATA_W-1:0] w_main_q;
  logic [DATA_W-1:0] w_skid_q;

  assign w_out_valid = (r_state != PSTG_EMPTY);
  assign w_in_fire   = in_valid_i & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= PSTG_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Main always holds the oldest entry, so refills from skid keep FIFO order
  always_comb begin
    w_state_nxt     = r_state;
    w_main_load     = 1'b0;
    w_main_sel_skid = 1'b0;
    case (r_state)
      PSTG_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = PSTG_ONE;
          w_main_load = 1'b1;
        end
      end
      PSTG_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = PSTG_TWO;
        end else if (w_out_fire) begin
          w_state_nxt = PSTG_EMPTY;
        end
      end
      PSTG_TWO: begin
        if (w_out_fire) begin
          w_state_nxt     = PSTG_ONE;
          w_main_load     = 1'b1;
          w_main_sel_skid = 1'b1;
        end
      end
      default: w_state_nxt = PSTG_EMPTY;
    endcase
    if (flush_i) w_state_nxt = PSTG_EMPTY;
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : in_data_i;

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk    (clk),
    .i_load (w_main_load),
    .i_data (w_main_d),
    .o_data (w_main_q)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic w_skid_load;
      assign w_skid_load = w_in_fire & ~w_out_fire & (r_state == PSTG_ONE);
      assign w_in_ready  = (r_state != PSTG_TWO);

      pipe_slot #(.DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .i_load (w_skid_load),
        .i_data (in_data_i),
        .o_data (w_skid_q)
      );
    end else begin : g_noskid
      assign w_skid_q   = {DATA_W{1'b0}};
      assign w_in_ready = ~w_out_valid | out_ready_i;
    end
  endgenerate

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign out_data_o  = w_out_valid ? w_main_q : BUBBLE_VAL;
  assign count_o     = r_state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid-enabled instance driven from a vector
// table, plus hand sequences for async reset and the single-entry variant.
module tb_pipe_stage_skid;

  localparam int            DW     = 8;
  localparam logic [DW-1:0] BUBBLE = 8'hEE;

  logic          clk = 1'b0;
  logic          rst = 1'b0;

  logic          skFlush = 1'b0, skInValid = 1'b0, skOutReady = 1'b0;
  logic [DW-1:0] skInData = '0;
  logic          skInReady, skOutValid;
  logic [DW-1:0] skOutData;
  logic [1:0]    skCount;

  logic          nsFlush = 1'b0, nsInValid = 1'b0, nsOutReady = 1'b0;
  logic [DW-1:0] nsInData = '0;
  logic          nsInReady, nsOutValid;
  logic [DW-1:0] nsOutData;
  logic [1:0]    nsCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUBBLE), .SKID_EN(1'b1)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (skFlush),
    .in_valid_i  (skInValid),
    .in_ready_o  (skInReady),
    .in_data_i   (skInData),
    .out_valid_o (skOutValid),
    .out_ready_i (skOutReady),
    .out_data_o  (skOutData),
    .count_o     (skCount)
  );

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE_VAL(BUBBLE), .SKID_EN(1'b0)) u_noskid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (nsFlush),
    .in_valid_i  (nsInValid),
    .in_ready_o  (nsInReady),
    .in_data_i   (nsInData),
    .out_valid_o (nsOutValid),
    .out_ready_i (nsOutReady),
    .out_data_o  (nsOutData),
    .count_o     (nsCount)
  );

  typedef struct {
    string         name;
    logic          flush;
    logic          inValid;
    logic [DW-1:0] inData;
    logic          outReady;
    logic          expValid;
    logic [DW-1:0] expData;
    logic          expReady;
    logic [1:0]    expCount;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string n, input logic f, input logic iv, input logic [DW-1:0] id,
                        input logic orr, input logic ev, input logic [DW-1:0] ed,
                        input logic er, input logic [1:0] ec);
    vec_t v;
    v.name = n; v.flush = f; v.inValid = iv; v.inData = id; v.outReady = orr;
    v.expValid = ev; v.expData = ed; v.expReady = er; v.expCount = ec;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic iv, input logic [DW-1:0] id, input logic orr);
    skFlush = f; skInValid = iv; skInData = id; skOutReady = orr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkSkid(input string n, input logic ev, input logic [DW-1:0] ed,
                           input logic er, input logic [1:0] ec);
    checkOutput({n, ".valid"}, 32'(skOutValid), 32'(ev));
    checkOutput({n, ".data"},  32'(skOutData),  32'(ed));
    checkOutput({n, ".ready"}, 32'(skInReady),  32'(er));
    checkOutput({n, ".count"}, 32'(skCount),    32'(ec));
  endtask

  initial begin
    // Expected state after each clock edge with the listed inputs applied before it
    for (int i = 0; i < 5; i++) addVec("idle", 0, 0, 8'h00, 0, 0, BUBBLE, 1, 0);
    for (int i = 1; i <= 8; i++) addVec("stream", 0, 1, 8'(i), 1, 1, 8'(i), 1, 1);
    addVec("streamDrain", 0, 0, 8'h00, 1, 0, BUBBLE, 1, 0);
    addVec("bpA1",     0, 1, 8'hA1, 0, 1, 8'hA1, 1, 1);
    addVec("bpA2",     0, 1, 8'hA2, 0, 1, 8'hA1, 0, 2);
    addVec("bpA3stall",0, 1, 8'hA3, 0, 1, 8'hA1, 0, 2);
    addVec("bpOutA1",  0, 1, 8'hA3, 1, 1, 8'hA2, 1, 1);
    addVec("bpOutA2",  0, 1, 8'hA3, 1, 1, 8'hA3, 1, 1);
    addVec("bpOutA3",  0, 0, 8'h00, 1, 0, BUBBLE, 1, 0);
    addVec("flB1",     0, 1, 8'hB1, 0, 1, 8'hB1, 1, 1);
    addVec("flB2",     0, 1, 8'hB2, 0, 1, 8'hB1, 0, 2);
    addVec("flFlush",  1, 1, 8'hB3, 0, 0, BUBBLE, 1, 0);
    addVec("flAfter",  0, 0, 8'h00, 1, 0, BUBBLE, 1, 0);
    addVec("fl1D1",    0, 1, 8'hD1, 0, 1, 8'hD1, 1, 1);
    addVec("fl1Flush", 1, 1, 8'hD2, 1, 0, BUBBLE, 1, 0);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkSkid("reset", 0, BUBBLE, 1, 0);
    checkOutput("nsReset.valid", 32'(nsOutValid), 32'd0);
    checkOutput("nsReset.data",  32'(nsOutData),  32'(BUBBLE));
    rst = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].flush, vecs[i].inValid, vecs[i].inData, vecs[i].outReady);
      tick();
      checkSkid($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].expValid, vecs[i].expData,
                vecs[i].expReady, vecs[i].expCount);
    end

    // Fill to two entries, then drop reset between edges
    applyStimulus(0, 1, 8'hC1, 0); tick();
    applyStimulus(0, 1, 8'hC2, 0); tick();
    applyStimulus(0, 0, 8'h00, 0);
    checkSkid("arFull", 1, 8'hC1, 0, 2);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkSkid("arAsync", 0, BUBBLE, 1, 0);
    tick();
    rst = 1'b1;
    applyStimulus(0, 0, 8'h00, 1); tick();
    checkSkid("arAfter", 0, BUBBLE, 1, 0);

    // Single-entry variant: combinational ready, simultaneous drain and load
    nsInValid = 1'b1; nsInData = 8'hC1; nsOutReady = 1'b0;
    tick();
    nsInValid = 1'b0;
    #1;
    checkOutput("nsHold.valid", 32'(nsOutValid), 32'd1);
    checkOutput("nsHold.data",  32'(nsOutData),  32'hC1);
    checkOutput("nsHold.ready", 32'(nsInReady),  32'd0);
    checkOutput("nsHold.count", 32'(nsCount),    32'd1);
    nsOutReady = 1'b1; nsInValid = 1'b1; nsInData = 8'hC2;
    #1;
    checkOutput("nsSwap.readyPre", 32'(nsInReady), 32'd1);
    tick();
    checkOutput("nsSwap.valid", 32'(nsOutValid), 32'd1);
    checkOutput("nsSwap.data",  32'(nsOutData),  32'hC2);
    checkOutput("nsSwap.count", 32'(nsCount),    32'd1);
    nsInValid = 1'b0;
    tick();
    checkOutput("nsDrain.valid", 32'(nsOutValid), 32'd0);
    checkOutput("nsDrain.data",  32'(nsOutData),  32'(BUBBLE));
    checkOutput("nsDrain.count", 32'(nsCount),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked replacement for the hard-wired inter-stage registers (ID/EX, EX/MEM, MEM/WB).
- Carries one opaque payload vector between stages using valid/ready flow control. An optional 2-entry skid buffer gives a fully registered in_ready_o.
- Supports flush, which inserts a bubble and outputs the configured NOP payload whenever the stage is empty.
- The payload is the concatenation of the stage fields; the EX/MEM instance is rd_addr, csr_waddr, wreg, csr_wreg, wdata, csr_wdata, opcode, funct3 = 157 bits.

Parameters:
- DATA_W, 157, payload width in bits (>=1).
- BUBBLE_VAL, {DATA_W{1'b0}}, payload presented on out_data_o when the stage holds nothing. The EX/MEM instance uses the addi-x0 NOP packing.
- SKID_EN, 1, selects buffering. 1 = 2-entry skid with registered in_ready_o. 0 = single entry with combinational in_ready_o.

Ports:
- clk  input  1  stage clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush_i  input  1  squash all held entries (branch/trap redirect).
- in_valid_i  input  1  upstream holds a valid payload.
- in_ready_o  output  1  stage can accept this cycle.
- in_data_i  input  DATA_W  upstream payload.
- out_valid_o  output  1  out_data_o is a real instruction.
- out_ready_i  input  1  downstream accepts this cycle.
- out_data_o  output  DATA_W  payload to next stage; BUBBLE_VAL when out_valid_o=0.
- count_o  output  2  entries held (0..2).

Behaviour:
- Fire definitions:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- Reset (rst low, async):
  - state=EMPTY, out_valid_o=0, out_data_o=BUBBLE_VAL, count_o=0.
  - in_ready_o=1.
  - Skid contents are don't-care.
- Latency: 1 cycle. A payload accepted at edge N is on out_data_o after edge N. There is no combinational in->out path.
- States when SKID_EN=1. main = output register, skid = overflow register.
  - EMPTY (count 0): in_fire -> ONE, main<=in_data_i.
  - ONE (count 1):
    - in_fire & out_fire -> ONE, main<=in_data_i.
    - in_fire only -> TWO, skid<=in_data_i.
    - out_fire only -> EMPTY.
    - neither -> hold.
  - TWO (count 2):
    - in_ready_o=0.
    - out_fire -> ONE, main<=skid.
    - otherwise hold.
  - in_ready_o = (state != TWO), decoded from the state flop only and independent of out_ready_i.
- SKID_EN=0 mode:
  - States EMPTY/ONE only; skid register is not instantiated.
  - in_ready_o = ~out_valid_o | out_ready_i.
  - ONE with in_fire & out_fire -> ONE with the new data.
- Ordering: strict FIFO. The skid entry always leaves after main.
- Stability: while out_valid_o=1 & out_ready_i=0, out_data_o and out_valid_o hold bit-exact.
- Flush:
  - The next state is EMPTY regardless of in_valid_i and out_ready_i. After the edge: out_valid_o=0, out_data_o=BUBBLE_VAL, count_o=0.
  - An in_fire in the same cycle is discarded, because upstream is flushed too. in_ready_o is not forced low.
  - An out_fire in the same cycle still counts as consumed by downstream.
- Empty output: out_data_o is muxed to BUBBLE_VAL whenever out_valid_o=0. Downstream logic needs no separate bubble decode.
- Reset mid-transfer: held entries are lost and no partial payload is ever presented.
- count_o is 0/1/2 matching EMPTY/ONE/TWO. It is registered with the state.

Decomposition:
- defines.v additions:
  - `EX_MEM_PAYLOAD_W (157), `EX_MEM_BUBBLE (NOP packing), and the field offset macros used to pack/unpack the payload.
  - State encodings `PSTG_EMPTY=2'd0, `PSTG_ONE=2'd1, `PSTG_TWO=2'd2.
- One sub-module, pipe_slot: DATA_W-wide data register with load enable, and no reset on the data. Instantiated for main and (SKID_EN=1 only) skid.
- Control FSM and output mux stay in pipe_stage_skid.

Test Plan:
- Reset then idle: rst low 3 cycles, release, in_valid_i=0 for 5 cycles -> out_valid_o=0, out_data_o=BUBBLE_VAL, in_ready_o=1, count_o=0 throughout.
- Streaming: out_ready_i=1, send 0x01..0x08 back-to-back -> each appears exactly 1 cycle after acceptance, in order, with in_ready_o held 1.
- Backpressure (SKID_EN=1): out_ready_i=0, send 0xA1,0xA2,0xA3 -> 0xA1,0xA2 accepted, count_o=2, in_ready_o=0, 0xA3 stalled. Raise out_ready_i -> output order 0xA1,0xA2,0xA3, no loss or duplicate.
- Flush while full: state TWO holding 0xB1,0xB2; flush_i=1 with in_valid_i=1 data 0xB3 -> next cycle count_o=0, out_valid_o=0, out_data_o=BUBBLE_VAL. 0xB3 never appears.
- Async reset mid-stall: state TWO, pull rst low between edges -> out_valid_o=0 and count_o=0 immediately, without waiting for a clock edge.
- SKID_EN=0: out_ready_i=0 with one entry held -> in_ready_o=0. Set out_ready_i=1 and in_valid_i=1 with 0xC2 in the same cycle -> 0xC1 drains and 0xC2 loads on the same edge.
